// File: rtl/prelu_stream_sequencer_if.sv
// Valid/ready activation stream bundle for the PReLU sequencer.
// The slave modport is the sequencer side; master is the producer/consumer side.
interface prelu_stream_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CH_W  = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CH_W-1:0]  out_ch;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_last
    );
endinterface

// File: rtl/prelu_stream_sequencer.sv
// Frame controller for the Q3.5 parametric-ReLU stream: per-channel alpha shifts, round-robin channels.
// Optional negative-input counter enabled with `define PRELU_NEG_COUNT_EN.
module prelu_stream_sequencer #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SHIFT_WIDTH   = 3,
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CH_W          = 2,
    parameter int unsigned LEN_W         = 16,
    parameter int unsigned DEFAULT_SHIFT = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_we,
    input  logic [CH_W-1:0]              cfg_addr,
    input  logic [SHIFT_WIDTH-1:0]       cfg_shift,
    input  logic                         start,
    input  logic [LEN_W-1:0]             frame_len,
    prelu_stream_sequencer_if.slave      strm,
`ifdef PRELU_NEG_COUNT_EN
    output logic [LEN_W-1:0]             neg_count,
`endif
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_W-1:0]       remaining_q, remaining_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       out_data_q, out_data_d;
    logic [CH_W-1:0]        out_ch_q, out_ch_d;
    logic                   out_last_q, out_last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [SHIFT_WIDTH-1:0] alpha_q [NUM_CH];

    logic                   in_ready_c;
    logic                   xfer_c;
    logic                   out_hs_c;
    logic signed [WIDTH-1:0] din_s;
    logic signed [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0]       result_c;

    // Handshake qualifiers; input is accepted only when the output slot frees this cycle.
    assign in_ready_c = (state_q == RUN) && (!out_valid_q || strm.out_ready);
    assign xfer_c     = strm.in_valid && in_ready_c;
    assign out_hs_c   = out_valid_q && strm.out_ready;

    // Negative inputs are scaled by 2^-alpha using the table value as it stood before this edge.
    assign din_s     = strm.in_data;
    assign shifted_s = din_s >>> alpha_q[ch_q];
    assign result_c  = din_s[WIDTH-1] ? WIDTH'(shifted_s) : WIDTH'(din_s);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                alpha_q[i] <= SHIFT_WIDTH'(DEFAULT_SHIFT);
            end
        end else if (cfg_we) begin
            alpha_q[cfg_addr] <= cfg_shift;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            ch_q        <= ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        ch_d        = ch_q;
        out_valid_d = out_valid_q && !strm.out_ready;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (frame_len != '0) begin
                        remaining_d = frame_len;
                        ch_d        = '0;
                        state_d     = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (xfer_c) begin
                    out_valid_d = 1'b1;
                    out_data_d  = result_c;
                    out_ch_d    = ch_q;
                    out_last_d  = (remaining_q == LEN_W'(1));
                    ch_d        = ch_q + CH_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_hs_c && out_last_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

`ifdef PRELU_NEG_COUNT_EN
    logic [LEN_W-1:0] neg_count_q;

    // Saturating count of negative inputs, restarted by any start accepted in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_count_q <= '0;
        end else if (state_q == IDLE && start) begin
            neg_count_q <= '0;
        end else if (xfer_c && strm.in_data[WIDTH-1] && (neg_count_q != '1)) begin
            neg_count_q <= neg_count_q + LEN_W'(1);
        end
    end

    assign neg_count = neg_count_q;
`endif

    assign strm.in_ready  = in_ready_c;
    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = out_data_q;
    assign strm.out_ch    = out_ch_q;
    assign strm.out_last  = out_last_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_prelu_stream_sequencer.sv
// Directed self-checking bench for prelu_stream_sequencer (default parameters).
module tb_prelu_stream_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [2:0]  cfg_shift;
    logic        start;
    logic [15:0] frame_len;
    logic        busy;
    logic        done;
`ifdef PRELU_NEG_COUNT_EN
    logic [15:0] neg_count;
`endif

    int errors = 0;
    int checks = 0;

    prelu_stream_sequencer_if #(.WIDTH(8), .CH_W(2)) bus ();

    prelu_stream_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_shift (cfg_shift),
        .start     (start),
        .frame_len (frame_len),
        .strm      (bus),
`ifdef PRELU_NEG_COUNT_EN
        .neg_count (neg_count),
`endif
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one element, require it to be accepted, and check the registered result.
    task automatic push(input logic [7:0] d, input logic [7:0] exp_d,
                        input logic [1:0] exp_ch, input logic exp_last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #1;
        check("push_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        check("out_valid", 32'(bus.out_valid), 32'd1);
        check("out_data", 32'(bus.out_data), 32'(exp_d));
        check("out_ch", 32'(bus.out_ch), 32'(exp_ch));
        check("out_last", 32'(bus.out_last), 32'(exp_last));
    endtask

    task automatic start_frame(input logic [15:0] len);
        start     = 1'b1;
        frame_len = len;
        tick();
        start     = 1'b0;
        frame_len = 16'd0;
    endtask

    // Last element is already registered with out_ready high; done follows the next edge.
    task automatic finish_frame(input string tag);
        check({tag, "_done_early"}, 32'(done), 32'd0);
        tick();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        check({tag, "_out_valid_off"}, 32'(bus.out_valid), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [2:0] s);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_shift = s;
        tick();
        cfg_we    = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        cfg_we        = 1'b0;
        cfg_addr      = 2'd0;
        cfg_shift     = 3'd0;
        start         = 1'b0;
        frame_len     = 16'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef PRELU_NEG_COUNT_EN
        check("rst_neg_count", 32'(neg_count), 32'd0);
`endif

        // Frame of 4 with default shift 2
        start_frame(16'd4);
        check("f1_busy", 32'(busy), 32'd1);
        push(8'h28, 8'h28, 2'd0, 1'b0);
        push(8'hE0, 8'hF8, 2'd1, 1'b0);
        push(8'hA0, 8'hE8, 2'd2, 1'b0);
        push(8'h80, 8'hE0, 2'd3, 1'b1);
        check("f1_in_ready_drain", 32'(bus.in_ready), 32'd0);
        finish_frame("f1");

        // Reprogram ch1=1, ch2=0
        cfg_write(2'd1, 3'd1);
        cfg_write(2'd2, 3'd0);
        start_frame(16'd3);
        push(8'hE0, 8'hF8, 2'd0, 1'b0);
        push(8'hE0, 8'hF0, 2'd1, 1'b0);
        push(8'hE0, 8'hE0, 2'd2, 1'b1);
        finish_frame("f2");

        // Backpressure with channel wrap; table is ch0=2 ch1=1 ch2=0 ch3=2
        start_frame(16'd6);
        push(8'h10, 8'h10, 2'd0, 1'b0);
        push(8'hC0, 8'hE0, 2'd1, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h90;
        #1;
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_data", 32'(bus.out_data), 32'hE0);
            check("bp_hold_ch", 32'(bus.out_ch), 32'd1);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        push(8'h90, 8'h90, 2'd2, 1'b0);
        push(8'hFF, 8'hFF, 2'd3, 1'b0);
        push(8'hE0, 8'hF8, 2'd0, 1'b0);
        push(8'h40, 8'h40, 2'd1, 1'b1);
        finish_frame("f3");

        // Zero-length frame
        start     = 1'b1;
        frame_len = 16'd0;
        tick();
        start     = 1'b0;
        check("zl_done", 32'(done), 32'd1);
        check("zl_busy", 32'(busy), 32'd0);
        check("zl_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("zl_done_pulse", 32'(done), 32'd0);

        // Start during RUN is ignored: frame still ends after 3 elements
        start_frame(16'd3);
        push(8'h08, 8'h08, 2'd0, 1'b0);
        start     = 1'b1;
        frame_len = 16'd10;
        push(8'h20, 8'h20, 2'd1, 1'b0);
        start     = 1'b0;
        frame_len = 16'd0;
        push(8'h70, 8'h70, 2'd2, 1'b1);
        finish_frame("f4");

        // Reset mid-frame after 2 of 5 elements
        start_frame(16'd5);
        push(8'hE0, 8'hF8, 2'd0, 1'b0);
        push(8'hE0, 8'hF0, 2'd1, 1'b0);
        reset = 1'b1;
        #1;
        check("mr_out_valid", 32'(bus.out_valid), 32'd0);
        check("mr_out_data", 32'(bus.out_data), 32'd0);
        check("mr_out_ch", 32'(bus.out_ch), 32'd0);
        check("mr_out_last", 32'(bus.out_last), 32'd0);
        check("mr_in_ready", 32'(bus.in_ready), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("mr_no_done", 32'(done), 32'd0);
        start_frame(16'd3);
        push(8'hE0, 8'hF8, 2'd0, 1'b0);
        push(8'hE0, 8'hF8, 2'd1, 1'b0);
        push(8'hE0, 8'hF8, 2'd2, 1'b1);
        finish_frame("f5");

`ifdef PRELU_NEG_COUNT_EN
        start_frame(16'd5);
        push(8'hF0, 8'hFC, 2'd0, 1'b0);
        push(8'h10, 8'h10, 2'd1, 1'b0);
        push(8'h80, 8'hE0, 2'd2, 1'b0);
        push(8'h00, 8'h00, 2'd3, 1'b0);
        push(8'hFC, 8'hFF, 2'd0, 1'b1);
        finish_frame("f6");
        check("nc_after_done", 32'(neg_count), 32'd3);
        start_frame(16'd1);
        check("nc_cleared", 32'(neg_count), 32'd0);
        push(8'h01, 8'h01, 2'd0, 1'b1);
        finish_frame("f7");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prelu_stream_sequencer.md
Name: prelu_stream_sequencer

Overview:
- Frame-level controller for the Q3.5 parametric-ReLU datapath.
- Accepts a valid/ready activation stream and assigns each element a channel index, round-robin.
- Applies that channel's programmed alpha shift (y = x >>> shift for negative x; pass-through otherwise) and emits a registered output stream.
- Sits between the conv/accumulator output stage and the activation buffer; owns the per-channel alpha table and the frame counter.

Parameters:
- WIDTH, 8, activation width, signed Q3.5
- SHIFT_WIDTH, 3, alpha shift-amount width (unsigned)
- NUM_CH, 4, number of channels in the alpha table (power of two, >=2)
- CH_W, 2, channel index width, log2(NUM_CH)
- LEN_W, 16, frame length counter width
- DEFAULT_SHIFT, 2, reset value of every alpha table entry

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- cfg_we  input  1  alpha table write strobe
- cfg_addr  input  CH_W  table entry to write
- cfg_shift  input  SHIFT_WIDTH  shift value to write
- start  input  1  start-of-frame pulse (IDLE only)
- frame_len  input  LEN_W  elements in the frame, sampled on start
- in_valid  input  1  input element valid
- in_ready  output  1  block accepts element this cycle
- in_data  input  WIDTH  signed Q3.5 input element
- out_valid  output  1  output element valid
- out_ready  input  1  downstream accepts output
- out_data  output  WIDTH  signed Q3.5 result
- out_ch  output  CH_W  channel index of out_data
- out_last  output  1  out_data is the final element of the frame
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all table entries = DEFAULT_SHIFT.
  - out_valid, out_data, out_ch, out_last, in_ready, busy, done all 0; counters 0.
  - Reset mid-frame aborts the frame; no done pulse.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - in_ready=0.
  - start with frame_len>0 -> latch remaining=frame_len, ch=0, go RUN.
  - start with frame_len==0 -> done=1 next cycle, stay IDLE.
- start outside IDLE is ignored.
- Input handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready). Combinational; full throughput with back-to-back transfers.
  - Transfer occurs when in_valid && in_ready.
  - On each transfer:
    - Output register loads the result next edge; latency 1 cycle.
    - out_ch=ch and out_last=(remaining==1) are registered alongside the result.
    - ch increments, wrapping NUM_CH-1 -> 0.
    - remaining decrements.
- Arithmetic:
  - in_data >= 0 -> out_data = in_data.
  - in_data < 0 -> out_data = in_data >>> table[ch], arithmetic shift with sign fill.
  - Shift 0 passes the value unchanged.
  - A shift >= WIDTH yields -1 (all ones) for a negative input.
  - No rounding.
- Output:
  - out_valid is held until out_ready.
  - out_data, out_ch and out_last stay stable while out_valid && !out_ready.
  - The output register clears out_valid on handshake unless a new transfer reloads it in the same cycle.
- RUN -> DRAIN on the transfer that makes remaining==0.
- DRAIN:
  - in_ready=0.
  - On the out_last handshake -> done=1 for one cycle and state=IDLE.
  - busy drops on the same edge.
- Config:
  - cfg_we is honoured in any state.
  - A write takes effect from the next cycle.
  - A same-cycle write and use of the same entry uses the old value.
- in_valid with in_ready=0 is not consumed.
- Data ignored when in_valid=0.

Optional Feature:
- Macro PRELU_NEG_COUNT_EN.
- When defined:
  - Adds output port neg_count[LEN_W-1:0], reset 0 and cleared on an accepted start.
  - Increments on every input transfer with in_data<0; saturates at all-ones.
  - Holds its value after done until the next start.
- When undefined: no port, no counter logic.

Test Plan:
- Reset, then start with frame_len=4; in_data 0x28, 0xE0, 0xA0, 0x80 back-to-back, out_ready=1, default shift 2 -> out_data 0x28, 0xF8, 0xE8, 0xE0; out_ch 0,1,2,3; out_last on 4th; done one cycle after last handshake.
- cfg write ch1=1, ch2=0 in IDLE; frame_len=3 with inputs 0xE0 (ch0), 0xE0 (ch1), 0xE0 (ch2) -> out_data 0xF8, 0xF0, 0xE0.
- Backpressure: frame_len=6, out_ready low for 3 cycles mid-frame -> in_ready=0 while stalled; out_data/out_ch held; no loss or duplication; channel wraps 3 -> 0 on 5th element.
- start with frame_len=0 -> done pulses next cycle, busy stays 0, in_ready stays 0; start during RUN ignored (remaining unchanged).
- Assert reset for one cycle during RUN after 2 of 5 elements -> all outputs 0 immediately, table back to DEFAULT_SHIFT, no done; new frame then runs normally.
- PRELU_NEG_COUNT_EN defined: frame of 5 inputs with 3 negatives -> neg_count=3 after done; next start clears it to 0.
